// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control bit positions,
// access-size encodings, multiply function codes and the FSM state type.
package mem_stage_pkg;

  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_REG_WRITE = 5;

  localparam logic [0:1] SIZE_BYTE = 2'b00;
  localparam logic [0:1] SIZE_HALF = 2'b01;

  localparam logic [0:5] ALU_MUL  = 6'h0e;
  localparam logic [0:5] ALU_MULU = 6'h16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic is_mult(input logic [0:5] func);
    return (func == ALU_MUL) || (func == ALU_MULU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load byte/half extraction with sign or zero extension, alignment check.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [0:1]  offset,
  input  logic [0:1]  size,
  input  logic        sign_ext,
  input  logic [0:31] store_data,
  input  logic [0:31] rdata,
  output logic [0:3]  be,
  output logic [0:31] wdata,
  output logic [0:31] load_val,
  output logic        misaligned
);

  logic [0:7]  byte_sel;
  logic [0:15] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[0:7];
      2'd1:    byte_sel = rdata[8:15];
      2'd2:    byte_sel = rdata[16:23];
      default: byte_sel = rdata[24:31];
    endcase
    half_sel = offset[0] ? rdata[16:31] : rdata[0:15];
  end

  // Reserved size 11 falls into the word branch.
  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    load_val   = rdata;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be       = 4'b1000 >> offset;
        wdata    = {4{store_data[24:31]}};
        load_val = {{24{sign_ext & byte_sel[0]}}, byte_sel};
      end
      SIZE_HALF: begin
        misaligned = offset[1];
        be         = offset[0] ? 4'b0011 : 4'b1100;
        wdata      = {2{store_data[16:31]}};
        load_val   = {{16{sign_ext & half_sel[0]}}, half_sel};
      end
      default: begin
        misaligned = |offset;
        be         = 4'b1111;
        wdata      = store_data;
        load_val   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake FSM, writeback value
// selection, forwarding taps and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [0:8]  ctrl,
  input  logic [0:5]  alu_ctrl,
  input  logic [0:31] alu_out,
  input  logic [0:31] mult_out,
  input  logic [0:31] write_data,
  input  logic [0:2]  dmem_info,
  input  logic [0:4]  write_reg,
  input  logic        fp_write,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [0:4]  write_reg_mem,
  output logic [0:31] write_val_mem,
  output logic        reg_write_mem,
  output logic        fp_write_mem,
  output logic [0:8]  ctrl_wb,
  output logic [0:31] result_wb,
  output logic [0:4]  write_reg_wb,
  output logic        reg_write_wb,
  output logic        fp_write_wb,
  output logic        fsm_state
);

  // Handshake: dmem_req stays high from issue until the edge where
  // dmem_ready is sampled high; request inputs are held stable meanwhile.

  state_t      state, state_next;
  logic        mem_read, mem_write, mem_op, access, fault_now, req_raw;
  logic [0:3]  be;
  logic [0:31] wdata, load_val, nonload_val, result;
  logic        misaligned;

  assign mem_read  = ctrl[CTRL_MEM_READ];
  assign mem_write = ctrl[CTRL_MEM_WRITE];
  assign mem_op    = mem_read | mem_write;
  assign access    = mem_op & ~misaligned;
  assign fault_now = mem_op & misaligned;

  mem_align u_align (
    .offset     (alu_out[30:31]),
    .size       (dmem_info[1:2]),
    .sign_ext   (dmem_info[0]),
    .store_data (write_data),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_val   (load_val),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          req_raw = 1'b1;
          if (!dmem_ready) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset gates the request directly so an in-flight access drops at once.
  assign dmem_req   = req_raw & ~reset;
  assign dmem_we    = dmem_req & mem_write;
  assign dmem_be    = dmem_req ? be : 4'b0000;
  assign dmem_wdata = wdata;
  assign dmem_addr  = {alu_out[0:29], 2'b00};
  assign mem_stall  = dmem_req & ~dmem_ready;
  assign fsm_state  = state;

  assign nonload_val   = is_mult(alu_ctrl) ? mult_out : alu_out;
  assign result        = ctrl[CTRL_MEM_TO_REG] ? load_val : nonload_val;
  assign write_val_mem = nonload_val;
  assign reg_write_mem = ctrl[CTRL_REG_WRITE];
  assign write_reg_mem = write_reg;
  assign fp_write_mem  = fp_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_wb      <= '0;
      result_wb    <= '0;
      write_reg_wb <= '0;
      reg_write_wb <= 1'b0;
      fp_write_wb  <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      mem_fault <= fault_now;
      if (mem_stall || fault_now) begin
        ctrl_wb      <= '0;
        result_wb    <= '0;
        write_reg_wb <= '0;
        reg_write_wb <= 1'b0;
        fp_write_wb  <= 1'b0;
      end else begin
        ctrl_wb      <= ctrl;
        result_wb    <= result;
        write_reg_wb <= write_reg;
        reg_write_wb <= ctrl[CTRL_REG_WRITE];
        fp_write_wb  <= fp_write;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized operations
// checked against an arithmetic reference model of the stage.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [0:8]  ctrl;
  logic [0:5]  alu_ctrl;
  logic [0:31] alu_out, mult_out, write_data;
  logic [0:2]  dmem_info;
  logic [0:4]  write_reg;
  logic        fp_write;
  logic [0:31] dmem_addr, dmem_wdata;
  logic [0:3]  dmem_be;
  logic        dmem_req, dmem_we;
  logic [0:31] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall, mem_fault;
  logic [0:4]  write_reg_mem;
  logic [0:31] write_val_mem;
  logic        reg_write_mem, fp_write_mem;
  logic [0:8]  ctrl_wb;
  logic [0:31] result_wb;
  logic [0:4]  write_reg_wb;
  logic        reg_write_wb, fp_write_wb;
  logic        fsm_state;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .mult_out(mult_out), .write_data(write_data),
    .dmem_info(dmem_info), .write_reg(write_reg), .fp_write(fp_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .mem_stall(mem_stall), .mem_fault(mem_fault),
    .write_reg_mem(write_reg_mem), .write_val_mem(write_val_mem),
    .reg_write_mem(reg_write_mem), .fp_write_mem(fp_write_mem),
    .ctrl_wb(ctrl_wb), .result_wb(result_wb), .write_reg_wb(write_reg_wb),
    .reg_write_wb(reg_write_wb), .fp_write_wb(fp_write_wb),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_mis(input logic [31:0] addr, input logic [2:0] info);
    int unsigned sz = info % 4;
    if (sz == 0) return 1'b0;
    if (sz == 1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] info,
                                             input logic [31:0] rd);
    int unsigned sz = info % 4;
    int unsigned k  = addr % 4;
    logic sgn = (info / 4) != 0;
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> (24 - 8 * k)) & 32'hff;
      if (sgn && v >= 32'd128) v = v + 32'hffff_ff00;
    end else if (sz == 1) begin
      v = (rd >> (16 - 8 * k)) & 32'hffff;
      if (sgn && v >= 32'd32768) v = v + 32'hffff_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_be(input logic [31:0] addr, input logic [2:0] info);
    int unsigned sz = info % 4;
    int unsigned k  = addr % 4;
    if (sz == 0) return 32'(1 << (3 - k));
    if (sz == 1) return (k == 0) ? 32'hc : 32'h3;
    return 32'hf;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] info);
    int unsigned sz = info % 4;
    if (sz == 0) return (wd & 32'hff) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hffff) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [0:8] mk_ctrl(input logic rd, input logic wr, input logic m2r,
                                         input logic rw);
    logic [0:8] c = '0;
    c[2] = rd; c[3] = wr; c[4] = m2r; c[5] = rw;
    return c;
  endfunction

  // ---------------- driver / checker for one instruction ----------------
  // Called just after a rising edge; returns just after the edge that
  // retires the instruction into MEM/WB.
  task automatic do_op(input logic [0:8] c, input logic [0:5] ac, input logic [31:0] ao,
                       input logic [31:0] mo, input logic [31:0] wd, input logic [2:0] info,
                       input logic [4:0] wr, input logic fw, input logic [31:0] rd,
                       input int delay);
    logic mem_op, mis, acc;
    logic [31:0] nonload, exp_res;
    mem_op  = c[2] | c[3];
    mis     = model_mis(ao, info);
    acc     = mem_op && !mis;
    nonload = (ac == 6'h0e || ac == 6'h16) ? mo : ao;
    exp_res = c[4] ? model_load(ao, info, rd) : nonload;

    ctrl = c; alu_ctrl = ac; alu_out = ao; mult_out = mo; write_data = wd;
    dmem_info = info; write_reg = wr; fp_write = fw; dmem_rdata = rd;
    dmem_ready = acc ? (delay == 0) : 1'($urandom_range(0, 1));
    #1;
    chk("req", dmem_req, acc);
    chk("fwd_val", write_val_mem, nonload);
    chk("fwd_rw", reg_write_mem, c[5]);
    chk("fwd_reg", write_reg_mem, wr);
    chk("fwd_fp", fp_write_mem, fw);
    chk("stall", mem_stall, acc && delay > 0);
    if (acc) begin
      chk("addr", dmem_addr, ao & 32'hffff_fffc);
      chk("we", dmem_we, c[3]);
      if (c[3]) begin
        chk("be", dmem_be, model_be(ao, info));
        chk("wdata", dmem_wdata, model_wdata(wd, info));
      end
      for (int i = 1; i <= delay; i++) begin
        @(posedge clk); #1;
        chk("bubble_rw", reg_write_wb, 1'b0);
        chk("bubble_ctrl", ctrl_wb, 9'h0);
        chk("bubble_res", result_wb, 32'h0);
        chk("wait_req", dmem_req, 1'b1);
        if (i == delay) dmem_ready = 1'b1;
        #1;
        chk("wait_stall", mem_stall, i < delay);
      end
    end
    @(posedge clk); #1;
    if (mem_op && mis) begin
      chk("fault", mem_fault, 1'b1);
      chk("fault_rw", reg_write_wb, 1'b0);
      chk("fault_ctrl", ctrl_wb, 9'h0);
    end else begin
      chk("fault_clr", mem_fault, 1'b0);
      chk("ctrl_wb", ctrl_wb, c);
      chk("result_wb", result_wb, exp_res);
      chk("wreg_wb", write_reg_wb, wr);
      chk("rw_wb", reg_write_wb, c[5]);
      chk("fp_wb", fp_write_wb, fw);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic clear_inputs();
    ctrl = '0; alu_ctrl = '0; alu_out = '0; mult_out = '0; write_data = '0;
    dmem_info = '0; write_reg = '0; fp_write = 1'b0; dmem_rdata = '0; dmem_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [0:8]  c;
    logic [31:0] ao, rdv;
    logic [2:0]  info;
    logic [5:0]  ac;
    int          kind;

    reset = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_res", result_wb, 32'h0);
    chk("rst_ctrl", ctrl_wb, 9'h0);
    chk("rst_fault", mem_fault, 1'b0);
    chk("rst_rw", reg_write_wb, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ALU result passthrough
    do_op(mk_ctrl(0, 0, 0, 1), 6'h01, 32'h0000_1234, 32'h0, 32'h0, 3'b010, 5'd5, 1'b0, 32'h0, 0);
    // Signed and unsigned byte loads at offset 3
    do_op(mk_ctrl(1, 0, 1, 1), 6'h00, 32'h103, 32'h0, 32'h0, 3'b100, 5'd7, 1'b0, 32'h1122_33f0, 0);
    do_op(mk_ctrl(1, 0, 1, 1), 6'h00, 32'h103, 32'h0, 32'h0, 3'b000, 5'd7, 1'b0, 32'h1122_33f0, 0);
    // Half store at offset 2
    do_op(mk_ctrl(0, 1, 0, 0), 6'h00, 32'h202, 32'h0, 32'h0000_beef, 3'b001, 5'd0, 1'b0, 32'h0, 0);
    // Word load, ready held off for 3 cycles
    do_op(mk_ctrl(1, 0, 1, 1), 6'h00, 32'h100, 32'h0, 32'h0, 3'b010, 5'd9, 1'b1, 32'hcafe_f00d, 3);
    // Misaligned word load, then an ALU op to see the fault pulse end
    do_op(mk_ctrl(1, 0, 1, 1), 6'h00, 32'h102, 32'h0, 32'h0, 3'b010, 5'd3, 1'b0, 32'h1, 0);
    do_op(mk_ctrl(0, 0, 0, 1), 6'h0e, 32'h0000_0040, 32'h0000_0c00, 32'h0, 3'b010, 5'd4, 1'b0, 32'h0, 0);
    // Back-to-back accesses with signed half load of a negative value
    do_op(mk_ctrl(1, 0, 1, 1), 6'h00, 32'h302, 32'h0, 32'h0, 3'b101, 5'd6, 1'b0, 32'h1234_8001, 0);
    do_op(mk_ctrl(0, 1, 0, 0), 6'h00, 32'h301, 32'h0, 32'h0000_00a5, 3'b000, 5'd0, 1'b0, 32'h0, 1);

    // Reset during WAIT aborts the access at once
    ctrl = mk_ctrl(1, 0, 1, 1); alu_out = 32'h400; dmem_info = 3'b010; write_reg = 5'd2;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("wait_req_pre", dmem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstw_req", dmem_req, 1'b0);
    chk("rstw_stall", mem_stall, 1'b0);
    chk("rstw_res", result_wb, 32'h0);
    chk("rstw_ctrl", ctrl_wb, 9'h0);
    chk("rstw_rw", reg_write_wb, 1'b0);
    chk("rstw_fault", mem_fault, 1'b0);
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomized mix of ALU, multiply, load and store operations
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 3);
      info = 3'($urandom_range(0, 7));
      ao   = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (info[1:0] == 2'b01) ao = ao & 32'hffff_fffe;
        else if (info[1:0] != 2'b00) ao = ao & 32'hffff_fffc;
      end
      ac = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 6'h0e : 6'h16)
                                       : 6'($urandom_range(0, 63));
      rdv = $urandom();
      case (kind)
        2:       c = mk_ctrl(1, 0, 1, 1);
        3:       c = mk_ctrl(0, 1, 0, 1'($urandom_range(0, 1)));
        default: c = mk_ctrl(0, 0, 0, 1'($urandom_range(0, 1)));
      endcase
      c[0] = 1'($urandom_range(0, 1));
      c[7] = 1'($urandom_range(0, 1));
      do_op(c, ac, ao, $urandom(), $urandom(), info, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), rdv, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
